// File: rtl/ifu_fetch_responder.sv
// Instruction-memory responder for IFU fetches: fixed-latency read pipeline
// feeding a credit-limited in-order response buffer.
module ifu_fetch_responder #(
    parameter int              XLEN   = 64,
    parameter logic [XLEN-1:0] BASE   = XLEN'(64'h8000_0000),
    parameter int              DEPTH  = 1024,
    parameter int              LAT    = 2,
    parameter int              QDEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [XLEN-1:0]          req_addr,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [31:0]              rsp_inst,
    output logic                     rsp_err,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_idx,
    input  logic [31:0]              wr_data
);
    localparam int              IW    = $clog2(DEPTH);
    localparam int              QW    = $clog2(QDEPTH);
    localparam logic [XLEN-1:0] LIMIT = XLEN'(DEPTH) << 2;
    localparam logic [31:0]     NOP   = 32'h0000_0013;

    logic [31:0]     mem [DEPTH];
    logic [XLEN-1:0] off;
    logic [IW-1:0]   idx;
    logic            accept;
    logic            s0_err;
    logic [31:0]     s0_inst;
    logic            up;

    logic            o_v;
    logic [31:0]     o_inst;
    logic            o_err;
    logic [QW:0]     p_cnt;

    logic [31:0]     q_inst [QDEPTH];
    logic [QDEPTH-1:0] q_err;
    logic [QW-1:0]   wptr;
    logic [QW-1:0]   rptr;
    logic [QW:0]     count;
    logic [QW:0]     inflight;
    logic            push;
    logic            pop;

    assign off     = req_addr - BASE;
    assign idx     = off[IW+1:2];
    assign s0_err  = (off[1:0] != 2'b00) || (off >= LIMIT);
    assign s0_inst = s0_err ? NOP : mem[idx];
    assign accept  = req_valid && req_ready;

    // Combinational read sees the pre-edge word: read-before-write
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_idx] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) up <= 1'b0;
        else      up <= 1'b1;
    end

    generate
        if (LAT == 1) begin : g_nopipe
            assign o_v    = accept;
            assign o_inst = s0_inst;
            assign o_err  = s0_err;
            assign p_cnt  = '0;
        end else begin : g_pipe
            logic [LAT-2:0] v;
            logic [LAT-2:0] e;
            logic [31:0]    d [LAT-1];

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    v <= '0;
                end else begin
                    v[0] <= accept;
                    for (int i = 1; i < LAT - 1; i++) v[i] <= v[i-1];
                end
            end

            always_ff @(posedge clk) begin
                d[0] <= s0_inst;
                e[0] <= s0_err;
                for (int i = 1; i < LAT - 1; i++) begin
                    d[i] <= d[i-1];
                    e[i] <= e[i-1];
                end
            end

            always_comb begin
                p_cnt = '0;
                for (int i = 0; i < LAT - 1; i++) p_cnt = p_cnt + (QW+1)'(v[i]);
            end

            assign o_v    = v[LAT-2];
            assign o_inst = d[LAT-2];
            assign o_err  = e[LAT-2];
        end
    endgenerate

    assign push = o_v;
    assign pop  = rsp_valid && rsp_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            count <= count + (QW+1)'(push) - (QW+1)'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_inst[wptr] <= o_inst;
            q_err[wptr]  <= o_err;
        end
    end

    // Credits cover every accepted request, so a push always finds room
    assign inflight  = p_cnt + count;
    assign req_ready = up && (inflight < (QW+1)'(QDEPTH));
    assign rsp_valid = (count != '0);
    assign rsp_inst  = rsp_valid ? q_inst[rptr] : '0;
    assign rsp_err   = rsp_valid && q_err[rptr];
endmodule

// File: tb/tb_ifu_fetch_responder.sv
// Randomized bench for ifu_fetch_responder against a transaction-level
// model: a queue of accepted fetches, each maturing LAT cycles later.
module tb_ifu_fetch_responder;
    localparam int LAT    = 2;
    localparam int QDEPTH = 4;
    localparam logic [63:0] BASE = 64'h8000_0000;

    typedef struct {
        int          c;
        logic [31:0] inst;
        logic        err;
    } item_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [63:0] req_addr = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_inst;
    logic        rsp_err;
    logic        wr_en = 1'b0;
    logic [9:0]  wr_idx = '0;
    logic [31:0] wr_data = '0;

    int    n_chk = 0;
    int    n_err = 0;
    int    cyc = 0;
    int    acc_cnt = 0;
    bit    rdy_m = 1'b0;
    bit    last_acc;
    item_t q[$];
    logic [31:0] mm [1024];

    ifu_fetch_responder #(
        .XLEN(64), .BASE(BASE), .DEPTH(1024), .LAT(LAT), .QDEPTH(QDEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_inst(rsp_inst), .rsp_err(rsp_err),
        .wr_en(wr_en), .wr_idx(wr_idx), .wr_data(wr_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic item_t mk(input logic [63:0] a, input int c);
        item_t it;
        logic [63:0] off;
        off = a - BASE;
        it.c = c;
        it.err = (off % 4 != 0) || (off >= 64'd4096);
        it.inst = it.err ? 32'h0000_0013 : mm[off[11:2]];
        return it;
    endfunction

    task automatic step();
        bit ev, er, pop;
        @(negedge clk);
        ev = (q.size() > 0) && (q[0].c + LAT <= cyc);
        er = rdy_m && (q.size() < QDEPTH);
        chk("rsp_valid", {31'b0, rsp_valid}, {31'b0, ev});
        chk("req_ready", {31'b0, req_ready}, {31'b0, er});
        if (ev) begin
            chk("rsp_inst", rsp_inst, q[0].inst);
            chk("rsp_err", {31'b0, rsp_err}, {31'b0, q[0].err});
        end
        last_acc = req_valid && er;
        pop = ev && rsp_ready;
        @(posedge clk);
        if (pop) void'(q.pop_front());
        if (last_acc) begin
            q.push_back(mk(req_addr, cyc));
            acc_cnt++;
        end
        if (wr_en) mm[wr_idx] = wr_data;
        if (rst) rdy_m = 1'b1;
        cyc++;
        #1;
    endtask

    task automatic preload(input int idx, input logic [31:0] d);
        wr_en = 1'b1;
        wr_idx = 10'(idx);
        wr_data = d;
        step();
        wr_en = 1'b0;
    endtask

    task automatic drain();
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 20 && q.size() > 0; i++) step();
        chk("drain", 32'(q.size()), 32'd0);
    endtask

    initial begin
        logic [63:0] bad [3];
        int k;
        bad[0] = 64'h7FFF_FFFC;
        bad[1] = 64'h8000_1000;
        bad[2] = 64'h8000_0006;

        #1;
        chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("rst_req_ready", {31'b0, req_ready}, 32'd0);
        chk("rst_rsp_inst", rsp_inst, 32'd0);
        chk("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
        step();
        step();
        rst = 1'b1;

        preload(0, 32'h0000_0093);
        preload(1, 32'h0010_0113);
        preload(2, 32'h0020_0193);
        preload(3, 32'h0030_0213);

        rsp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            req_valid = 1'b1;
            req_addr = BASE + 64'(4 * i);
            step();
        end
        req_valid = 1'b0;
        for (int i = 0; i < 5; i++) step();

        foreach (bad[i]) begin
            req_valid = 1'b1;
            req_addr = bad[i];
            step();
        end
        req_addr = 64'h8000_0002;
        step();
        drain();

        rsp_ready = 1'b0;
        acc_cnt = 0;
        req_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            req_addr = BASE + 64'(4 * (acc_cnt % 4));
            step();
        end
        chk("credit_accepts", 32'(acc_cnt), 32'd4);
        req_valid = 1'b0;
        drain();

        preload(5, 32'h1111_1111);
        wr_en = 1'b1;
        wr_idx = 10'd5;
        wr_data = 32'hDEAD_BEEF;
        req_valid = 1'b1;
        req_addr = 64'h8000_0014;
        step();
        wr_en = 1'b0;
        step();
        drain();

        for (int i = 0; i < 16; i++) preload(i, 32'h0A00_0000 + 32'(i * 3));
        k = 0;
        for (int i = 0; i < 300; i++) begin
            rsp_ready = 1'($urandom_range(1));
            req_valid = ($urandom_range(7) != 0);
            if ($urandom_range(9) == 0) req_addr = bad[$urandom_range(2)];
            else req_addr = BASE + 64'(4 * (k % 16));
            step();
            if (last_acc) k++;
        end
        drain();

        rsp_ready = 1'b0;
        req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req_addr = BASE + 64'(4 * i);
            step();
        end
        req_valid = 1'b0;
        rst = 1'b0;
        #1;
        chk("midrst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        chk("midrst_req_ready", {31'b0, req_ready}, 32'd0);
        chk("midrst_rsp_inst", rsp_inst, 32'd0);
        q.delete();
        rdy_m = 1'b0;
        step();
        step();
        rst = 1'b1;
        rsp_ready = 1'b1;
        for (int i = 0; i < 6; i++) step();
        req_valid = 1'b1;
        req_addr = BASE + 64'd8;
        step();
        req_addr = BASE + 64'd12;
        step();
        drain();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule
